// File: rtl/rv_pkg.sv
// Shared definitions for the memory/load-store pipeline stage.
//   XLEN_DEFAULT : default datapath width
//   SIZE_*       : access size codes carried in funct3[1:0]
//   lsu_state_e  : request FSM states
`timescale 1ns/1ps
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for data-memory accesses (purely combinational).
// Ports:
//   addr_off_i   : byte offset within the bus word (alu result low bits)
//   size_i       : access size code (B/H/W)
//   unsigned_i   : 1 = zero-extend loads, 0 = sign-extend
//   store_data_i : raw rs2 value
//   rdata_i      : raw bus read data
//   be_o         : byte enables
//   wdata_o      : lane-replicated store data
//   load_data_o  : extracted and extended load value
//   misalign_o   : misaligned H/W access (only when MEM_LSU_MISALIGN_TRAP_EN is defined)
// Without MEM_LSU_MISALIGN_TRAP_EN, H ignores offset bit 0 and W ignores the offset.
`timescale 1ns/1ps
module lsu_align
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [OFF_W-1:0]  addr_off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              misalign_o
);

  localparam int unsigned BE_W = XLEN / 8;

  logic [1:0]       size_n;
  logic [OFF_W-1:0] off;
  logic [XLEN-1:0]  shifted;
  logic             sext;

  // Reserved size code 2'b11 is treated as a word access.
  assign size_n = (size_i == 2'b11) ? SIZE_W : size_i;
  assign sext   = ~unsigned_i;

  // Lane selection, store replication and load extraction.
  always_comb begin
    off         = '0;
    be_o        = '1;
    wdata_o     = store_data_i;
    shifted     = rdata_i;
    load_data_o = rdata_i;
    case (size_n)
      SIZE_B: begin
        off         = addr_off_i;
        be_o        = BE_W'(1) << off;
        wdata_o     = {(XLEN/8){store_data_i[7:0]}};
        shifted     = rdata_i >> {off, 3'b000};
        load_data_o = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        off         = {addr_off_i[OFF_W-1:1], 1'b0};
        be_o        = BE_W'(2'b11) << off;
        wdata_o     = {(XLEN/16){store_data_i[15:0]}};
        shifted     = rdata_i >> {off, 3'b000};
        load_data_o = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        off         = '0;
        be_o        = '1;
        wdata_o     = store_data_i;
        shifted     = rdata_i;
        load_data_o = rdata_i;
      end
    endcase
  end

  // Misalignment flag.
  always_comb begin
    misalign_o = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    case (size_n)
      SIZE_B:  misalign_o = 1'b0;
      SIZE_H:  misalign_o = addr_off_i[0];
      default: misalign_o = |addr_off_i;
    endcase
`else
    misalign_o = 1'b0;
`endif
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: issues data-memory requests, waits for grant/read data,
// aligns data and registers the MEM/WB pipeline outputs.
// Ports:
//   clk, rst (sync, active-high)
//   EXE/MEM inputs : valid_mem, instr_mem, alu_mem, store_data_mem, mem_en,
//                    mem_wr, funct3_mem, rd_addr_mem
//   stall_mem      : upstream must hold its inputs
//   dmem_*         : data-memory request/response bus (request side combinational)
//   *_wb, err_wb   : registered MEM/WB outputs
// Config macro: MEM_LSU_MISALIGN_TRAP_EN (misaligned H/W trap without a bus request).
`timescale 1ns/1ps
module mem_lsu_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned WAIT_MAX       = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_mem,
  input  logic [XLEN-1:0]           instr_mem,
  input  logic [XLEN-1:0]           alu_mem,
  input  logic [XLEN-1:0]           store_data_mem,
  input  logic                      mem_en,
  input  logic                      mem_wr,
  input  logic [2:0]                funct3_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
  output logic                      stall_mem,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN/8-1:0]         dmem_be,
  output logic [XLEN-1:0]           dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic                      valid_wb,
  output logic [XLEN-1:0]           instr_wb,
  output logic [XLEN-1:0]           alu_wb,
  output logic [XLEN-1:0]           mem_wb,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_wb,
  output logic                      err_wb
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  lsu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            is_mem_c, misalign_c, timeout_c, gnt_done_c;
  logic            done_c, err_c, load_ok_c;
  logic [XLEN-1:0] load_data_c;

  logic                      valid_q;
  logic [XLEN-1:0]           instr_q, alu_q, mem_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      err_q;

  lsu_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .addr_off_i   (alu_mem[OFF_W-1:0]),
    .size_i       (funct3_mem[1:0]),
    .unsigned_i   (funct3_mem[2]),
    .store_data_i (store_data_mem),
    .rdata_i      (dmem_rdata),
    .be_o         (dmem_be),
    .wdata_o      (dmem_wdata),
    .load_data_o  (load_data_c),
    .misalign_o   (misalign_c)
  );

  assign is_mem_c   = valid_mem & mem_en;
  // A grant finishes a store outright, or a load whose data arrives alongside it.
  assign gnt_done_c = dmem_gnt & (mem_wr | dmem_rvalid);
  assign timeout_c  = (cnt_q == CNT_W'(WAIT_MAX - 1));
  assign dmem_we    = dmem_req & mem_wr;
  assign dmem_addr  = {alu_mem[XLEN-1:OFF_W], {OFF_W{1'b0}}};

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_mem_c && !misalign_c) begin
          if (gnt_done_c)    state_d = ST_IDLE;
          else if (dmem_gnt) state_d = ST_WAIT;
          else               state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (timeout_c)     state_d = ST_IDLE;
        else if (dmem_gnt) state_d = gnt_done_c ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_rvalid || timeout_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Counter runs only while an access is outstanding; zero otherwise.
    cnt_d = (state_q == ST_IDLE || state_d == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
  end

  // Request, stall and completion outputs.
  always_comb begin
    dmem_req  = 1'b0;
    stall_mem = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    load_ok_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_mem) begin
          if (!mem_en) begin
            done_c = 1'b1;
          end else if (misalign_c) begin
            done_c = 1'b1;
            err_c  = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (gnt_done_c) begin
              done_c    = 1'b1;
              load_ok_c = ~mem_wr;
            end else begin
              stall_mem = 1'b1;
            end
          end
        end
      end
      ST_REQ: begin
        if (timeout_c) begin
          done_c = 1'b1;
          err_c  = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (gnt_done_c) begin
            done_c    = 1'b1;
            load_ok_c = ~mem_wr;
          end else begin
            stall_mem = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          done_c    = 1'b1;
          load_ok_c = 1'b1;
        end else if (timeout_c) begin
          done_c = 1'b1;
          err_c  = 1'b1;
        end else begin
          stall_mem = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      dmem_req  = 1'b0;
      stall_mem = 1'b0;
      done_c    = 1'b0;
      err_c     = 1'b0;
      load_ok_c = 1'b0;
    end
  end

  // MEM/WB registers: capture on completion, otherwise hold with valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else if (done_c) begin
      valid_q <= 1'b1;
      instr_q <= instr_mem;
      alu_q   <= alu_mem;
      mem_q   <= load_ok_c ? load_data_c : '0;
      rd_q    <= rd_addr_mem;
      err_q   <= err_c;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign valid_wb   = valid_q;
  assign instr_wb   = instr_q;
  assign alu_wb     = alu_q;
  assign mem_wb     = mem_q;
  assign rd_addr_wb = rd_q;
  assign err_wb     = err_q;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed self-checking bench for mem_lsu_stage (default parameters).
`timescale 1ns/1ps
module tb_mem_lsu_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            clk;
  logic            rst;
  logic            valid_mem;
  logic [XLEN-1:0] instr_mem, alu_mem, store_data_mem;
  logic            mem_en, mem_wr;
  logic [2:0]      funct3_mem;
  logic [RW-1:0]   rd_addr_mem;
  logic            stall_mem, dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_gnt, dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            valid_wb;
  logic [XLEN-1:0] instr_wb, alu_wb, mem_wb;
  logic [RW-1:0]   rd_addr_wb;
  logic            err_wb;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_lsu_stage #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .valid_mem(valid_mem), .instr_mem(instr_mem),
    .alu_mem(alu_mem), .store_data_mem(store_data_mem), .mem_en(mem_en),
    .mem_wr(mem_wr), .funct3_mem(funct3_mem), .rd_addr_mem(rd_addr_mem),
    .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .valid_wb(valid_wb), .instr_wb(instr_wb), .alu_wb(alu_wb), .mem_wb(mem_wb),
    .rd_addr_wb(rd_addr_wb), .err_wb(err_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_idle();
    valid_mem = 0; mem_en = 0; mem_wr = 0; funct3_mem = 3'b000;
    instr_mem = '0; alu_mem = '0; store_data_mem = '0; rd_addr_mem = '0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    step(); step();
    valid_mem = 1; mem_en = 1; funct3_mem = 3'b010; alu_mem = 32'h100;
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", dmem_req); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", stall_mem); end
    step();
    n_cmp++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL rst_valid_wb: got %b exp 0", valid_wb); end
    n_cmp++; if (err_wb !== 1'b0) begin n_fail++; $display("FAIL rst_err_wb: got %b exp 0", err_wb); end
    n_cmp++; if (alu_wb !== 32'h0) begin n_fail++; $display("FAIL rst_alu_wb: got %h exp 0", alu_wb); end
    drive_idle(); rst = 0;
  endtask

  task automatic test_passthrough();
    valid_mem = 1; instr_mem = 32'h00B5_0533; alu_mem = 32'h1234; rd_addr_mem = 5'd10;
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL add_req: got %b exp 0", dmem_req); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b exp 0", stall_mem); end
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1) begin n_fail++; $display("FAIL add_valid_wb: got %b exp 1", valid_wb); end
    n_cmp++; if (alu_wb !== 32'h1234) begin n_fail++; $display("FAIL add_alu_wb: got %h exp 00001234", alu_wb); end
    n_cmp++; if (instr_wb !== 32'h00B5_0533) begin n_fail++; $display("FAIL add_instr_wb: got %h exp 00b50533", instr_wb); end
    n_cmp++; if (rd_addr_wb !== 5'd10) begin n_fail++; $display("FAIL add_rd_wb: got %0d exp 10", rd_addr_wb); end
    n_cmp++; if (mem_wb !== 32'h0) begin n_fail++; $display("FAIL add_mem_wb: got %h exp 0", mem_wb); end
    step();
    n_cmp++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL add_valid_pulse: got %b exp 0", valid_wb); end
    n_cmp++; if (alu_wb !== 32'h1234) begin n_fail++; $display("FAIL add_alu_hold: got %h exp 00001234", alu_wb); end
  endtask

  task automatic test_back_to_back();
    valid_mem = 1; alu_mem = 32'hA;
    step();
    n_cmp++; if (valid_wb !== 1'b1 || alu_wb !== 32'hA) begin n_fail++; $display("FAIL b2b_first: got v=%b alu=%h exp v=1 alu=0000000a", valid_wb, alu_wb); end
    alu_mem = 32'hB;
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || alu_wb !== 32'hB) begin n_fail++; $display("FAIL b2b_second: got v=%b alu=%h exp v=1 alu=0000000b", valid_wb, alu_wb); end
    step();
    n_cmp++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b exp 0", valid_wb); end
  endtask

  task automatic test_lb();
    int stalls;
    stalls = 0;
    valid_mem = 1; mem_en = 1; mem_wr = 0; funct3_mem = 3'b000; alu_mem = 32'h103; rd_addr_mem = 5'd3;
    #1;
    n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL lb_req: got req=%b we=%b exp req=1 we=0", dmem_req, dmem_we); end
    n_cmp++; if (dmem_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b exp 1000", dmem_be); end
    n_cmp++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h exp 00000100", dmem_addr); end
    if (stall_mem === 1'b1) stalls++;
    step(); dmem_gnt = 1; #1;
    n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin n_fail++; $display("FAIL lb_req_hold: got req=%b addr=%h exp req=1 addr=00000100", dmem_req, dmem_addr); end
    if (stall_mem === 1'b1) stalls++;
    step(); dmem_gnt = 0; #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lb_wait_req: got %b exp 0", dmem_req); end
    if (stall_mem === 1'b1) stalls++;
    step(); dmem_rvalid = 1; dmem_rdata = 32'h80FF_FF7F; #1;
    if (stall_mem === 1'b1) stalls++;
    n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d exp 3", stalls); end
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || err_wb !== 1'b0) begin n_fail++; $display("FAIL lb_wb: got v=%b err=%b exp v=1 err=0", valid_wb, err_wb); end
    n_cmp++; if (mem_wb !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h exp ffffff80", mem_wb); end
  endtask

  task automatic test_stores();
    valid_mem = 1; mem_en = 1; mem_wr = 1; funct3_mem = 3'b001; alu_mem = 32'h202;
    store_data_mem = 32'h0000_ABCD; dmem_gnt = 1;
    #1;
    n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL sh_req: got req=%b we=%b exp 1 1", dmem_req, dmem_we); end
    n_cmp++; if (dmem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b exp 1100", dmem_be); end
    n_cmp++; if (dmem_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h exp abcdabcd", dmem_wdata); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL sh_stall: got %b exp 0", stall_mem); end
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || mem_wb !== 32'h0 || err_wb !== 1'b0) begin n_fail++; $display("FAIL sh_wb: got v=%b mem=%h err=%b exp 1 0 0", valid_wb, mem_wb, err_wb); end
    // SB with one cycle of grant delay
    valid_mem = 1; mem_en = 1; mem_wr = 1; funct3_mem = 3'b000; alu_mem = 32'h201;
    store_data_mem = 32'h1234_5678;
    #1;
    n_cmp++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h7878_7878) begin n_fail++; $display("FAIL sb_lanes: got be=%b wdata=%h exp 0010 78787878", dmem_be, dmem_wdata); end
    n_cmp++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL sb_stall: got %b exp 1", stall_mem); end
    step(); dmem_gnt = 1; #1;
    n_cmp++; if (stall_mem !== 1'b0 || dmem_req !== 1'b1) begin n_fail++; $display("FAIL sb_gnt: got stall=%b req=%b exp 0 1", stall_mem, dmem_req); end
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1) begin n_fail++; $display("FAIL sb_wb: got %b exp 1", valid_wb); end
  endtask

  task automatic test_load_variants();
    // LHU: grant and data together in the REQ state
    valid_mem = 1; mem_en = 1; mem_wr = 0; funct3_mem = 3'b101; alu_mem = 32'h102;
    step(); dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h80FF_FF7F; #1;
    n_cmp++; if (stall_mem !== 1'b0 || dmem_be !== 4'b1100) begin n_fail++; $display("FAIL lhu_req: got stall=%b be=%b exp 0 1100", stall_mem, dmem_be); end
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || mem_wb !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_data: got v=%b mem=%h exp 1 000080ff", valid_wb, mem_wb); end
    // LW at a misaligned address
    valid_mem = 1; mem_en = 1; funct3_mem = 3'b010; alu_mem = 32'h101;
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; #1;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    n_cmp++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin n_fail++; $display("FAIL lw_mis_req: got req=%b stall=%b exp 0 0", dmem_req, stall_mem); end
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || err_wb !== 1'b1 || mem_wb !== 32'h0) begin n_fail++; $display("FAIL lw_mis_wb: got v=%b err=%b mem=%h exp 1 1 0", valid_wb, err_wb, mem_wb); end
`else
    n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin n_fail++; $display("FAIL lw_mis_req: got req=%b addr=%h be=%b exp 1 00000100 1111", dmem_req, dmem_addr, dmem_be); end
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || err_wb !== 1'b0 || mem_wb !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_mis_wb: got v=%b err=%b mem=%h exp 1 0 deadbeef", valid_wb, err_wb, mem_wb); end
    // LH at odd address ignores bit 0
    valid_mem = 1; mem_en = 1; funct3_mem = 3'b001; alu_mem = 32'h103;
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h8001_0000; #1;
    n_cmp++; if (dmem_be !== 4'b1100) begin n_fail++; $display("FAIL lh_odd_be: got %b exp 1100", dmem_be); end
    step(); drive_idle();
    n_cmp++; if (mem_wb !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_odd_data: got %h exp ffff8001", mem_wb); end
`endif
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    valid_mem = 1; mem_en = 1; mem_wr = 0; funct3_mem = 3'b010; alu_mem = 32'h300;
    #1;
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #2;
    end
    n_cmp++; if (n !== 15) begin n_fail++; $display("FAIL to_req_cycles: got %0d exp 15", n); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL to_stall: got %b exp 0", stall_mem); end
    @(posedge clk); #1; drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || err_wb !== 1'b1 || mem_wb !== 32'h0) begin n_fail++; $display("FAIL to_wb: got v=%b err=%b mem=%h exp 1 1 0", valid_wb, err_wb, mem_wb); end
    step();
    n_cmp++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b exp 0", valid_wb); end
  endtask

  task automatic test_reset_in_wait();
    valid_mem = 1; mem_en = 1; mem_wr = 0; funct3_mem = 3'b010; alu_mem = 32'h400; dmem_gnt = 1;
    #1;
    n_cmp++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL rw_issue_stall: got %b exp 1", stall_mem); end
    step(); dmem_gnt = 0; #1;
    n_cmp++; if (stall_mem !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rw_wait: got stall=%b req=%b exp 1 0", stall_mem, dmem_req); end
    rst = 1; #1;
    n_cmp++; if (stall_mem !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL rw_rst_outs: got stall=%b req=%b exp 0 0", stall_mem, dmem_req); end
    step(); rst = 0; drive_idle(); dmem_rvalid = 1; dmem_rdata = 32'h55;
    n_cmp++; if (valid_wb !== 1'b0 || alu_wb !== 32'h0) begin n_fail++; $display("FAIL rw_cleared: got v=%b alu=%h exp 0 0", valid_wb, alu_wb); end
    step(); dmem_rvalid = 0;
    n_cmp++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL rw_late_rvalid: got %b exp 0", valid_wb); end
    valid_mem = 1; alu_mem = 32'h77;
    step(); drive_idle();
    n_cmp++; if (valid_wb !== 1'b1 || alu_wb !== 32'h77) begin n_fail++; $display("FAIL rw_idle_after: got v=%b alu=%h exp 1 00000077", valid_wb, alu_wb); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_lb();
    test_stores();
    test_load_variants();
    test_timeout();
    test_reset_in_wait();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
